ras_spec_ctrl: RTL

- Speculation controller sitting between the fetch/decode front end and the return-address stack.
- Accepts call/return/branch-checkpoint requests under a valid/ready handshake and forwards them to the stack as push/pop/din.
- Allocates in-order branch tags and tracks out-of-order resolutions.
- Converts resolutions into in-order per-level commit pulses and per-level flush pulses on the stack's commit/flush vectors; stalls the front end during flush recovery.

---
 rtl/ras_spec_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ras_spec_ctrl.sv
// Speculation controller between the front end and the return-address stack.
// Optional statistics counters are enabled with RAS_SPEC_CTRL_STATS_EN.
module ras_spec_ctrl #(
   parameter int unsigned STAGES       = 2,
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned MAX_BRANCHES = 16,
   parameter int unsigned FLUSH_LAT    = 2,
   localparam int unsigned TAG_W       = $clog2(MAX_BRANCHES),
   localparam int unsigned LVL_W       = (STAGES > 1) ? $clog2(STAGES) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_call,
   input  logic              req_ret,
   input  logic [WIDTH-1:0]  req_addr,
   input  logic              req_branch,
   input  logic [LVL_W-1:0]  req_level,
   output logic [TAG_W-1:0]  req_tag,
   input  logic              res_valid,
   input  logic [TAG_W-1:0]  res_tag,
   input  logic              res_mispredict,
   output logic              ras_push,
   output logic              ras_pop,
   output logic [WIDTH-1:0]  ras_din,
   output logic [STAGES-1:0] ras_commit,
   output logic [STAGES-1:0] ras_flush,
`ifdef RAS_SPEC_CTRL_STATS_EN
   output logic [31:0]       stat_commits,
   output logic [31:0]       stat_flushes,
   output logic [31:0]       stat_stalls,
`endif
   output logic              busy
);

   localparam int unsigned CNT_W = TAG_W + 1;

   typedef enum logic {RUN = 1'b0, FLUSH_WAIT = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [3:0]        flush_cnt_q, flush_cnt_d;
   logic [TAG_W-1:0]  head_q, tail_q;
   logic [CNT_W-1:0]  count_q;
   logic [LVL_W-1:0]  level_q [MAX_BRANCHES];
   logic [MAX_BRANCHES-1:0] resolved_q;

   logic [TAG_W-1:0]  res_rel;
   logic              res_live, mis, good, fire, alloc, retire;

   // Liveness is always measured as distance from head.
   assign res_rel   = res_tag - head_q;
   assign res_live  = {1'b0, res_rel} < count_q;
   assign mis       = res_valid && res_mispredict && res_live;
   assign good      = res_valid && !res_mispredict && res_live;

   assign req_ready = (state_q == RUN)
                      && !(req_branch && (count_q == CNT_W'(MAX_BRANCHES)))
                      && !mis;
   assign fire      = req_valid && req_ready;
   assign alloc     = fire && req_branch;
   assign retire    = (count_q != '0) && resolved_q[head_q] && !mis;

   assign ras_push  = fire && req_call;
   assign ras_pop   = fire && req_ret;
   assign ras_din   = req_addr;
   assign req_tag   = tail_q;
   assign busy      = (state_q == FLUSH_WAIT);

   // Checkpoint queue and commit/flush pulses.
   always_ff @(posedge clk) begin
      if (reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         resolved_q <= '0;
         ras_commit <= '0;
         ras_flush  <= '0;
         for (int i = 0; i < int'(MAX_BRANCHES); i++) level_q[i] <= '0;
      end else begin
         ras_commit <= retire ? (STAGES'(1) << level_q[head_q]) : '0;
         ras_flush  <= mis ? (STAGES'(1) << level_q[res_tag]) : '0;
         if (alloc) begin
            level_q[tail_q]    <= req_level;
            resolved_q[tail_q] <= 1'b0;
         end
         if (good) resolved_q[res_tag] <= 1'b1;
         if (retire) head_q <= head_q + TAG_W'(1);
         if (mis) begin
            // Keep the mispredicted checkpoint, squash everything younger.
            tail_q  <= res_tag + TAG_W'(1);
            count_q <= CNT_W'(res_rel) + CNT_W'(1);
         end else begin
            tail_q  <= tail_q + TAG_W'(alloc);
            count_q <= count_q + CNT_W'(alloc) - CNT_W'(retire);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Flush recovery: stall for FLUSH_LAT cycles, restarted by each mispredict.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      case (state_q)
         RUN: begin
            if (mis) begin
               state_d     = FLUSH_WAIT;
               flush_cnt_d = 4'(FLUSH_LAT);
            end
         end
         FLUSH_WAIT: begin
            if (mis) begin
               flush_cnt_d = 4'(FLUSH_LAT);
            end else if (flush_cnt_q <= 4'd1) begin
               state_d = RUN;
            end else begin
               flush_cnt_d = flush_cnt_q - 4'd1;
            end
         end
         default: state_d = RUN;
      endcase
   end

`ifdef RAS_SPEC_CTRL_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         stat_commits <= '0;
         stat_flushes <= '0;
         stat_stalls  <= '0;
      end else begin
         if (retire && (stat_commits != '1)) stat_commits <= stat_commits + 32'd1;
         if (mis && (stat_flushes != '1))    stat_flushes <= stat_flushes + 32'd1;
         if (req_valid && !req_ready && (stat_stalls != '1))
            stat_stalls <= stat_stalls + 32'd1;
      end
   end
`endif

endmodule
